// File: rtl/dcache_pkg.sv
// Shared types and constants for the dCache miss-service engine.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    RF_REQ,
    RF_WAIT,
    DONE
  } refill_state_t;

  localparam logic MEM_WR = 1'b1;
  localparam logic MEM_RD = 1'b0;

  // Word-index width for a line with the given byte-offset width (32-bit words).
  function automatic int widx_width(input int offset_width);
    return offset_width - 2;
  endfunction

endpackage

// File: rtl/dcache_refill_cnt.sv
// Loadable wrapping word counter plus a transferred-word count whose 'last' flag marks the final word of a line.
module dcache_refill_cnt #(
  parameter int WIDX_W = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load,
  input  logic [WIDX_W-1:0] load_val,
  input  logic              inc,
  output logic [WIDX_W-1:0] cnt,
  output logic              last
);

  logic [WIDX_W-1:0] xfer;

  // The word index may start mid-line and wrap; xfer always counts from zero so 'last' is order-independent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      xfer <= '0;
    end else if (load) begin
      cnt  <= load_val;
      xfer <= '0;
    end else if (inc) begin
      cnt  <= cnt + 1'b1;
      xfer <= xfer + 1'b1;
    end
  end

  assign last = &xfer;

endmodule

// File: rtl/dcache_refill_ctrl.sv
// dCache miss-service engine: optional victim writeback, word-by-word refill, miss_done pulse.
// Define DCACHE_CWF_EN to refill critical-word-first (wrapping); otherwise the refill runs from word 0.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int TAG_WIDTH    = 27,
  parameter int OFFSET_WIDTH = 5,
  parameter int LINE_NUM     = 8
) (
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 miss_req,
  input  logic [31:0]                          miss_addr,
  input  logic [31:0]                          victim_id,
  input  logic                                 victim_valid,
  input  logic                                 victim_dirty,
  input  logic [TAG_WIDTH-1:0]                 victim_tag,
  input  logic [31:0]                          victim_rdata,
  output logic [widx_width(OFFSET_WIDTH)-1:0]  rd_widx,
  output logic                                 line_we,
  output logic [31:0]                          line_id,
  output logic [widx_width(OFFSET_WIDTH)-1:0]  line_widx,
  output logic [31:0]                          line_wdata,
  output logic [TAG_WIDTH-1:0]                 line_tag,
  output logic                                 crit_valid,
  output logic [31:0]                          crit_data,
  output logic                                 miss_done,
  output logic                                 busy,
  output logic                                 mem_req,
  output logic                                 mem_wr,
  output logic [31:0]                          mem_addr,
  output logic [31:0]                          mem_wdata,
  input  logic                                 mem_addr_ok,
  input  logic                                 mem_data_ok,
  input  logic [31:0]                          mem_rdata
);

  localparam int WIDX_W = widx_width(OFFSET_WIDTH);
  localparam int ID_W   = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;

  refill_state_t     state, next;
  logic [TAG_WIDTH-1:0] tag_q, vtag_q;
  logic [WIDX_W-1:0] crit_q, cnt, start_in, start_q, cnt_load_val;
  logic [ID_W-1:0]   id_q;
  logic              cnt_load, cnt_inc, cnt_last, wb_beat, rf_beat, accept;
  logic              unused_bits;

  assign unused_bits = ^{miss_addr[1:0], victim_id[31:ID_W]};

`ifdef DCACHE_CWF_EN
  assign start_in = miss_addr[OFFSET_WIDTH-1:2];
  assign start_q  = crit_q;
`else
  assign start_in = '0;
  assign start_q  = '0;
`endif

  assign accept   = (state == IDLE) && miss_req;
  assign busy     = (state != IDLE);
  assign line_id  = {{(32-ID_W){1'b0}}, id_q};
  assign line_tag = tag_q;

  dcache_refill_cnt #(.WIDX_W(WIDX_W)) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .inc      (cnt_inc),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // Miss context is captured once at accept and held until the next accept.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      tag_q  <= '0;
      vtag_q <= '0;
      crit_q <= '0;
      id_q   <= '0;
    end else begin
      state <= next;
      if (accept) begin
        tag_q  <= miss_addr[31:OFFSET_WIDTH];
        vtag_q <= victim_tag;
        crit_q <= miss_addr[OFFSET_WIDTH-1:2];
        id_q   <= victim_id[ID_W-1:0];
      end
    end
  end

  always_comb begin
    next         = state;
    mem_req      = 1'b0;
    mem_wr       = MEM_RD;
    mem_addr     = '0;
    mem_wdata    = '0;
    rd_widx      = '0;
    line_we      = 1'b0;
    line_widx    = '0;
    line_wdata   = '0;
    crit_valid   = 1'b0;
    crit_data    = '0;
    miss_done    = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_inc      = 1'b0;
    wb_beat      = 1'b0;
    rf_beat      = 1'b0;

    // A beat completes on data_ok in WAIT, or in REQ when addr_ok and data_ok coincide.
    case (state)
      IDLE: begin
        if (miss_req) begin
          cnt_load = 1'b1;
          if (victim_valid && victim_dirty) begin
            cnt_load_val = '0;
            next         = WB_REQ;
          end else begin
            cnt_load_val = start_in;
            next         = RF_REQ;
          end
        end
      end
      WB_REQ: begin
        mem_req   = 1'b1;
        mem_wr    = MEM_WR;
        mem_addr  = {vtag_q, cnt, 2'b00};
        mem_wdata = victim_rdata;
        rd_widx   = cnt;
        if (mem_addr_ok) begin
          if (mem_data_ok) wb_beat = 1'b1;
          else             next    = WB_WAIT;
        end
      end
      WB_WAIT: begin
        rd_widx = cnt;
        if (mem_data_ok) wb_beat = 1'b1;
      end
      RF_REQ: begin
        mem_req  = 1'b1;
        mem_wr   = MEM_RD;
        mem_addr = {tag_q, cnt, 2'b00};
        if (mem_addr_ok) begin
          if (mem_data_ok) rf_beat = 1'b1;
          else             next    = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (mem_data_ok) rf_beat = 1'b1;
      end
      DONE: begin
        miss_done = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase

    if (wb_beat) begin
      if (cnt_last) begin
        cnt_load     = 1'b1;
        cnt_load_val = start_q;
        next         = RF_REQ;
      end else begin
        cnt_inc = 1'b1;
        next    = WB_REQ;
      end
    end

    if (rf_beat) begin
      line_we    = 1'b1;
      line_widx  = cnt;
      line_wdata = mem_rdata;
      if (cnt == crit_q) begin
        crit_valid = 1'b1;
        crit_data  = mem_rdata;
      end
      if (cnt_last) begin
        next = DONE;
      end else begin
        cnt_inc = 1'b1;
        next    = RF_REQ;
      end
    end
  end

endmodule
